// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and helpers for the L1 instruction-cache refill sequencer.
// Holds the FSM encoding, line geometry defaults and the line-align helper.
package icache_refill_ctrl_pkg;

  localparam int LINE_BYTES_DEF     = 16;
  localparam int LINE_OFFSET_BITS   = $clog2(LINE_BYTES_DEF);
  localparam int TIMEOUT_CYCLES_DEF = 64;
  localparam int CNT_W_DEF          = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_FILL   = 2'd2,
    S_REPLAY = 2'd3
  } state_t;

  // Clears the byte-offset bits so the address names a whole line.
  function automatic logic [31:0] line_align(input logic [31:0] addr,
                                             input int unsigned off_bits);
    line_align = addr & ~((32'h1 << off_bits) - 32'h1);
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Miss/refill sequencer for the L1 instruction cache: stalls the PC on a miss,
// fetches and writes the line, and replays any branch redirect seen while stalled.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int LINE_BYTES     = LINE_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [31:0]      fetch_addr,
  input  logic             cache_hit,
  input  logic             redirect,
  input  logic [31:0]      redirect_target,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ready,
  input  logic [127:0]     mem_data,
  output logic             fill_we,
  output logic [31:0]      fill_addr,
  output logic [127:0]     fill_data,
  output logic             pc_stall,
  output logic             pc_redirect,
  output logic [31:0]      pc_redirect_addr,
  output logic             inst_valid,
  output logic [CNT_W-1:0] miss_count,
  output logic             timeout_err,
  output logic [1:0]       fsm_state
);

  localparam int unsigned OFF_BITS = $clog2(LINE_BYTES);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  // Handshake: mem_req stays high every WAIT cycle; a single-cycle mem_ready
  // completes the transfer and mem_data is taken in that same cycle.
  state_t           state, state_nxt;
  logic [31:0]      line_addr;
  logic             pend;
  logic [31:0]      pend_tgt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_last;
  logic             miss_start;

  assign tmo_last  = (tmo_cnt == TMO_LAST);
  assign mem_addr  = line_addr;
  assign fill_addr = line_addr;
  assign fsm_state = state;

  always_comb begin
    state_nxt        = state;
    mem_req          = 1'b0;
    fill_we          = 1'b0;
    pc_stall         = 1'b0;
    pc_redirect      = 1'b0;
    pc_redirect_addr = redirect_target;
    inst_valid       = 1'b0;
    miss_start       = 1'b0;
    case (state)
      S_IDLE: begin
        // Held quiet while in reset so no stall or valid leaks out.
        if (Rst_n) begin
          if (redirect) begin
            pc_redirect = 1'b1;
          end else if (!cache_hit) begin
            pc_stall   = 1'b1;
            miss_start = 1'b1;
            state_nxt  = S_WAIT;
          end else begin
            inst_valid = 1'b1;
          end
        end
      end
      S_WAIT: begin
        mem_req  = 1'b1;
        pc_stall = 1'b1;
        if (mem_ready) begin
          state_nxt = S_FILL;
        end else if (tmo_last) begin
          state_nxt = (pend || redirect) ? S_REPLAY : S_IDLE;
        end
      end
      S_FILL: begin
        fill_we   = 1'b1;
        pc_stall  = 1'b1;
        // A redirect landing in this very cycle must still be replayed.
        state_nxt = (pend || redirect) ? S_REPLAY : S_IDLE;
      end
      S_REPLAY: begin
        pc_redirect      = 1'b1;
        pc_redirect_addr = redirect ? redirect_target : pend_tgt;
        state_nxt        = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state       <= S_IDLE;
      line_addr   <= '0;
      pend        <= 1'b0;
      pend_tgt    <= '0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
      fill_data   <= '0;
    end else begin
      state <= state_nxt;
      if (miss_start) begin
        line_addr <= line_align(fetch_addr, OFF_BITS);
        tmo_cnt   <= '0;
      end
      if (state == S_WAIT) begin
        if (mem_ready) begin
          fill_data <= mem_data;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_last) timeout_err <= 1'b1;
        end
      end
      if (state == S_REPLAY) begin
        pend <= 1'b0;
      end else if ((state != S_IDLE) && redirect) begin
        pend     <= 1'b1;
        pend_tgt <= redirect_target;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (Clk),
    .clr_n (Rst_n),
    .en    (miss_start),
    .count (miss_count)
  );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: directed plan plus randomized
// refill transactions checked against a transaction-level expectation model.
module tb_icache_refill_ctrl;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic [31:0]  fetch_addr;
  logic         cache_hit;
  logic         redirect;
  logic [31:0]  redirect_target;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready;
  logic [127:0] mem_data;
  logic         fill_we;
  logic [31:0]  fill_addr;
  logic [127:0] fill_data;
  logic         pc_stall;
  logic         pc_redirect;
  logic [31:0]  pc_redirect_addr;
  logic         inst_valid;
  logic [15:0]  miss_count;
  logic         timeout_err;
  logic [1:0]   fsm_state;

  icache_refill_ctrl dut (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .fetch_addr       (fetch_addr),
    .cache_hit        (cache_hit),
    .redirect         (redirect),
    .redirect_target  (redirect_target),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ready        (mem_ready),
    .mem_data         (mem_data),
    .fill_we          (fill_we),
    .fill_addr        (fill_addr),
    .fill_data        (fill_data),
    .pc_stall         (pc_stall),
    .pc_redirect      (pc_redirect),
    .pc_redirect_addr (pc_redirect_addr),
    .inst_valid       (inst_valid),
    .miss_count       (miss_count),
    .timeout_err      (timeout_err),
    .fsm_state        (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- scoreboard / model state ----------------
  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_q[$];
  logic [15:0]  exp_miss = '0;
  logic         exp_tmo  = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] align16(input logic [31:0] a);
    return a & 32'hFFFF_FFF0;
  endfunction

  function automatic void count_miss();
    if (exp_miss != 16'hFFFF) exp_miss = exp_miss + 16'd1;
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change just after a falling edge; outputs are checked 1ns later.
  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic quiet_inputs();
    cache_hit       = 1'b1;
    redirect        = 1'b0;
    redirect_target = '0;
    mem_ready       = 1'b0;
    mem_data        = '0;
  endtask

  task automatic hit_cycle(input logic [31:0] addr);
    quiet_inputs();
    fetch_addr = addr;
    #1;
    check("hit_inst_valid", inst_valid, 1);
    check("hit_pc_stall", pc_stall, 0);
    check("hit_mem_req", mem_req, 0);
    check("hit_miss_count", miss_count, exp_miss);
    tick();
  endtask

  // One full refill: miss cycle, lat+1 WAIT cycles, FILL, optional REPLAY.
  // redir_at in 0..lat picks a WAIT cycle, lat+1 picks the FILL cycle, -1 none.
  task automatic do_refill(input logic [31:0] addr, input int lat, input logic [127:0] data,
                           input int redir_at, input logic [31:0] tgt);
    quiet_inputs();
    fetch_addr = addr;
    cache_hit  = 1'b0;
    #1;
    check("miss_pc_stall", pc_stall, 1);
    check("miss_mem_req", mem_req, 0);
    check("miss_pc_redirect", pc_redirect, 0);
    count_miss();
    exp_q.push_back(data);
    tick();
    for (int k = 0; k <= lat; k++) begin
      mem_ready       = (k == lat);
      mem_data        = (k == lat) ? data : {$urandom, $urandom, $urandom, $urandom};
      redirect        = (k == redir_at);
      redirect_target = (k == redir_at) ? tgt : 32'h0;
      #1;
      check("wait_mem_req", mem_req, 1);
      check("wait_mem_addr", mem_addr, align16(addr));
      check("wait_pc_stall", pc_stall, 1);
      check("wait_fill_we", fill_we, 0);
      tick();
    end
    mem_ready       = 1'b0;
    redirect        = (redir_at == lat + 1);
    redirect_target = (redir_at == lat + 1) ? tgt : 32'h0;
    #1;
    check("fill_we", fill_we, 1);
    check("fill_addr", fill_addr, align16(addr));
    if (exp_q.size() == 0) check("fill_queue_empty", 1, 0);
    else check("fill_data", fill_data, exp_q.pop_front());
    check("fill_pc_stall", pc_stall, 1);
    check("fill_mem_req", mem_req, 0);
    tick();
    redirect = 1'b0;
    if (redir_at >= 0) begin
      #1;
      check("replay_pc_redirect", pc_redirect, 1);
      check("replay_addr", pc_redirect_addr, tgt);
      check("replay_pc_stall", pc_stall, 0);
      check("replay_fill_we", fill_we, 0);
      tick();
    end
    #1;
    check("post_fill_we", fill_we, 0);
    check("post_pc_redirect", pc_redirect, 0);
    hit_cycle(addr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [31:0] a;
    logic [31:0] t;
    int lat;
    int ra;

    quiet_inputs();
    fetch_addr = 32'h0000_0010;
    Rst_n = 1'b0;
    tick();
    tick();
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_fill_we", fill_we, 0);
    check("rst_pc_stall", pc_stall, 0);
    check("rst_pc_redirect", pc_redirect, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_miss_count", miss_count, 0);
    check("rst_timeout_err", timeout_err, 0);
    Rst_n = 1'b1;
    tick();

    // Hit stream
    for (int i = 0; i < 5; i++) hit_cycle(32'h0000_0010);

    // Basic miss, memory answers 3 cycles after the request
    do_refill(32'h0000_012C, 3, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, -1, 32'h0);
    check("basic_miss_count", miss_count, 1);

    // Redirect in the second WAIT cycle
    do_refill(32'h0000_0200, 3, 128'h11112222_33334444_55556666_77778888, 1, 32'h0000_0400);

    // Redirect coincident with a miss in IDLE: wrong-path miss is dropped
    quiet_inputs();
    fetch_addr      = 32'h0000_0300;
    cache_hit       = 1'b0;
    redirect        = 1'b1;
    redirect_target = 32'h0000_0080;
    #1;
    check("idle_redir_pc_redirect", pc_redirect, 1);
    check("idle_redir_addr", pc_redirect_addr, 32'h0000_0080);
    check("idle_redir_pc_stall", pc_stall, 0);
    tick();
    hit_cycle(32'h0000_0080);

    // Timeout: memory never answers
    quiet_inputs();
    fetch_addr = 32'h0000_0540;
    cache_hit  = 1'b0;
    #1;
    check("tmo_miss_pc_stall", pc_stall, 1);
    count_miss();
    tick();
    cache_hit = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (!mem_req) break;
      n++;
      tick();
    end
    check("tmo_req_cycles", n, 64);
    exp_tmo = 1'b1;
    check("tmo_err", timeout_err, exp_tmo);
    check("tmo_pc_stall", pc_stall, 0);
    check("tmo_fill_we", fill_we, 0);
    tick();
    do_refill(32'h0000_0548, 0, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, -1, 32'h0);
    check("tmo_err_sticky", timeout_err, exp_tmo);

    // Randomized refills and hit/redirect cycles
    for (int i = 0; i < 12; i++) begin
      a   = $urandom;
      lat = $urandom_range(0, 6);
      ra  = int'($urandom_range(0, lat + 2)) - 1;
      t   = $urandom & 32'hFFFF_FFFC;
      do_refill(a, lat, {$urandom, $urandom, $urandom, $urandom}, ra, t);
      if ($urandom_range(0, 1) == 1) begin
        quiet_inputs();
        fetch_addr      = $urandom;
        cache_hit       = $urandom_range(0, 1) == 1;
        redirect        = 1'b1;
        redirect_target = $urandom & 32'hFFFF_FFFC;
        #1;
        check("rand_idle_redir", pc_redirect, 1);
        check("rand_idle_redir_addr", pc_redirect_addr, redirect_target);
        check("rand_idle_redir_stall", pc_stall, 0);
        tick();
      end
      hit_cycle($urandom);
    end
    check("rand_miss_count", miss_count, exp_miss);

    // Reset in the middle of WAIT, then a late mem_ready
    quiet_inputs();
    fetch_addr = 32'h0000_0700;
    cache_hit  = 1'b0;
    tick();
    #1;
    check("rstw_in_wait", mem_req, 1);
    Rst_n = 1'b0;
    tick();
    Rst_n      = 1'b1;
    cache_hit  = 1'b1;
    mem_ready  = 1'b1;
    mem_data   = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
    exp_miss   = '0;
    exp_tmo    = 1'b0;
    #1;
    check("rstw_mem_req", mem_req, 0);
    check("rstw_fill_we", fill_we, 0);
    check("rstw_miss_count", miss_count, exp_miss);
    check("rstw_timeout_err", timeout_err, exp_tmo);
    check("rstw_inst_valid", inst_valid, 1);
    tick();
    mem_ready = 1'b0;
    #1;
    check("rstw_late_fill_we", fill_we, 0);
    check("rstw_late_mem_req", mem_req, 0);
    tick();
    hit_cycle(32'h0000_0700);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
